match_collector: RTL and testbench
==================================

MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning pair FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter MAX_DISP, default 11'd200, meaning the maximum accepted L1 displacement in pixels.
REQ-003 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port i_valid, input, 1, meaning a match pair is present this cycle (no backpressure upstream).
REQ-006 SHALL have port i_end, input, 1, meaning a single-cycle end-of-frame marker from the matcher.
REQ-007 SHALL have ports i_src_coor_x, i_src_coor_y, i_dst_coor_x and i_dst_coor_y, input, 10 each, meaning the pair coordinates.
REQ-008 SHALL have port i_ready, input, 1, meaning the downstream consumer accepts the output pair.
REQ-009 SHALL have port o_valid, output, 1, meaning the output pair is valid.
REQ-010 SHALL have ports o_src_coor_x, o_src_coor_y, o_dst_coor_x and o_dst_coor_y, output, 10 each, meaning the FIFO head pair.
REQ-011 SHALL have port o_last, output, 1, meaning the current output pair is the final pair of the frame.
REQ-012 SHALL have port o_frame_done, output, 1, meaning a one-cycle pulse when the frame is fully drained.
REQ-013 SHALL have port o_match_cnt, output, 12, meaning pairs accepted this frame (saturating at 4095).
REQ-014 SHALL have port o_drop_cnt, output, 12, meaning pairs dropped this frame (saturating at 4095).

Function
REQ-015 SHALL implement FSM states COLLECT (reset state), DRAIN and DONE.
REQ-016 In COLLECT, a pair with i_valid=1 SHALL be accepted if |dx|+|dy| <= MAX_DISP (dx = dst_x-src_x, computed in 11-bit magnitude; sum in 12 bits) and the FIFO was not full at cycle start.
REQ-017 A filtered-out pair, or a pair arriving while the FIFO is full, SHALL be dropped and SHALL increment o_drop_cnt; a simultaneous read SHALL NOT free space for a write in the same cycle.
REQ-018 An accepted pair SHALL increment o_match_cnt and SHALL appear on the outputs with o_valid=1 no earlier than one cycle after its write (first-word-fall-through, registered).
REQ-019 An output transfer SHALL occur when o_valid && i_ready; o_* data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-020 On i_end in COLLECT, the FSM SHALL enter DRAIN; a pair with i_valid in the same cycle as i_end SHALL be processed under REQ-016/017 first.
REQ-021 Pairs with i_valid=1 arriving in DRAIN or DONE SHALL be dropped and counted in o_drop_cnt.
REQ-022 In DRAIN, o_last SHALL be 1 exactly when o_valid=1 and the FIFO holds one entry.
REQ-023 When the FIFO is empty in DRAIN (including a frame with zero accepted pairs), the FSM SHALL enter DONE and assert o_frame_done for exactly one cycle.
REQ-024 In DONE, o_match_cnt and o_drop_cnt SHALL hold the final frame values; the FSM SHALL return to COLLECT on the next cycle, clearing both counters.
REQ-025 Pairs streamed out during COLLECT SHALL carry o_last=0.

Reset
REQ-026 While i_rst=1, the FSM SHALL be forced to COLLECT, the FIFO pointers cleared, and o_valid, o_last, o_frame_done, o_match_cnt and o_drop_cnt driven to 0; o_*_coor_* SHALL be 0.
REQ-027 Assertion of i_rst mid-frame SHALL discard all buffered pairs with no o_frame_done pulse.

Structure
REQ-028 Package match_pkg SHALL hold the coord_t (10-bit) type, the match_pair_t struct (src x/y, dst x/y), the collector state enum and the counter width constant (12).
REQ-029 A sub-module match_fifo (synchronous FWFT FIFO of match_pair_t, DEPTH entries, full/empty/count) SHALL be instantiated once.

Verification
REQ-030 Three pairs (0,0)->(5,5), (10,10)->(300,10), (20,20)->(25,22), then i_end, with i_ready=1 -> outputs are pairs 1 and 3 only, o_last on pair 3, o_frame_done with o_match_cnt=2 and o_drop_cnt=1.
REQ-031 i_ready=0 with 70 pairs of zero displacement, then i_end, then i_ready=1 -> 64 pairs drained in order, o_match_cnt=64, o_drop_cnt=6, o_last on the 64th.
REQ-032 i_end with no prior pairs -> o_frame_done pulses within 2 cycles, counts are 0, o_valid is never 1.
REQ-033 i_valid and i_end in the same cycle with a valid pair -> the pair is output with o_last=1 and o_match_cnt=1.
REQ-034 i_rst pulse after 5 accepted pairs -> o_valid=0 the next cycle, counters are 0, no o_frame_done.
REQ-035 Random i_ready toggling over 200 pairs -> output order and data match a scoreboard, and data is stable during stalls.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types for the match collector: coordinates, the pair struct,
// collector states and the per-frame counter width.
package match_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t src_x;
    coord_t src_y;
    coord_t dst_x;
    coord_t dst_y;
  } match_pair_t;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } coll_state_t;

  // L1 displacement: each axis is an 11-bit magnitude, and the sum needs 12 bits.
  function automatic logic [CNT_W-1:0] l1_disp(input match_pair_t p);
    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    dx = (p.dst_x >= p.src_x) ? {1'b0, p.dst_x - p.src_x} : {1'b0, p.src_x - p.dst_x};
    dy = (p.dst_y >= p.src_y) ? {1'b0, p.dst_y - p.src_y} : {1'b0, p.src_y - p.dst_y};
    return {1'b0, dx} + {1'b0, dy};
  endfunction

endpackage

// File: rtl/match_fifo.sv
// Synchronous FWFT FIFO of match pairs. The head sits in an output register,
// so it stays stable while valid is high and no read is taken.
module match_fifo
  import match_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  match_pair_t              wr_data,
  input  logic                     rd_en,
  output logic                     valid,
  output match_pair_t              data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  match_pair_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic          push;
  logic          pop;
  logic          load;

  // Occupancy covers both the array and the head register. It is taken at
  // cycle start, so a read in the same cycle never makes room for a write.
  assign count = mem_cnt + CW'(valid);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = valid && rd_en;
  assign load  = (mem_cnt != '0) && (!valid || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      valid   <= 1'b0;
      data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr <= rd_ptr + AW'(1);
        data   <= mem[rd_ptr];
        valid  <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CW'(push) - CW'(load);
    end
  end

endmodule

// File: rtl/match_collector.sv
// Per-frame match pair collector: it filters pairs by L1 displacement,
// buffers them, and drains them at end of frame with last / frame-done marking.
//
// state      | meaning
// ST_COLLECT | accept filtered pairs, stream them out, and wait for i_end
// ST_DRAIN   | drop new pairs and flush the FIFO, with o_last on the final entry
// ST_DONE    | one-cycle o_frame_done showing the final counts; counters clear on exit
module match_collector
  import match_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [10:0] MAX_DISP = 11'd200
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_end,
  input  logic [9:0]       i_src_coor_x,
  input  logic [9:0]       i_src_coor_y,
  input  logic [9:0]       i_dst_coor_x,
  input  logic [9:0]       i_dst_coor_y,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [9:0]       o_src_coor_x,
  output logic [9:0]       o_src_coor_y,
  output logic [9:0]       o_dst_coor_x,
  output logic [9:0]       o_dst_coor_y,
  output logic             o_last,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  coll_state_t      state;
  coll_state_t      state_nx;
  match_pair_t      in_pair;
  match_pair_t      head;
  logic             fifo_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             pass;
  logic             wr_en;
  logic             accept;
  logic             drop;
  logic             clr;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] drop_cnt;

  assign in_pair = '{src_x: i_src_coor_x, src_y: i_src_coor_y,
                     dst_x: i_dst_coor_x, dst_y: i_dst_coor_y};
  assign pass    = (l1_disp(in_pair) <= {1'b0, MAX_DISP});
  assign wr_en   = (state == ST_COLLECT) && i_valid && pass && !full;

  match_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_en),
    .wr_data (in_pair),
    .rd_en   (i_ready),
    .valid   (fifo_valid),
    .data    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_COLLECT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    drop     = 1'b0;
    clr      = 1'b0;
    case (state)
      ST_COLLECT: begin
        accept = wr_en;
        drop   = i_valid && !wr_en;
        if (i_end) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        drop = i_valid;
        if (empty) state_nx = ST_DONE;
      end
      ST_DONE: begin
        clr      = 1'b1;
        state_nx = ST_COLLECT;
      end
      default: state_nx = ST_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      match_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
      if (drop && (drop_cnt != '1))    drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end

  assign o_valid      = fifo_valid;
  assign o_src_coor_x = head.src_x;
  assign o_src_coor_y = head.src_y;
  assign o_dst_coor_x = head.dst_x;
  assign o_dst_coor_y = head.dst_y;
  assign o_last       = (state == ST_DRAIN) && fifo_valid && (count == CW'(1));
  assign o_frame_done = (state == ST_DONE);
  assign o_match_cnt  = match_cnt;
  assign o_drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_match_collector.sv
// Scoreboard bench for match_collector: directed frames, a mid-frame reset,
// and a randomized stream with random i_ready.
module tb_match_collector;

  localparam int MAX_D = 200;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_end = 1'b0;
  logic        i_ready = 1'b0;
  logic [9:0]  i_src_coor_x = '0;
  logic [9:0]  i_src_coor_y = '0;
  logic [9:0]  i_dst_coor_x = '0;
  logic [9:0]  i_dst_coor_y = '0;
  logic        o_valid;
  logic [9:0]  o_src_coor_x;
  logic [9:0]  o_src_coor_y;
  logic [9:0]  o_dst_coor_x;
  logic [9:0]  o_dst_coor_y;
  logic        o_last;
  logic        o_frame_done;
  logic [11:0] o_match_cnt;
  logic [11:0] o_drop_cnt;
  logic [39:0] out_data;

  always #5 i_clk = ~i_clk;

  match_collector #(.DEPTH(64), .MAX_DISP(11'd200)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_end        (i_end),
    .i_src_coor_x (i_src_coor_x),
    .i_src_coor_y (i_src_coor_y),
    .i_dst_coor_x (i_dst_coor_x),
    .i_dst_coor_y (i_dst_coor_y),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_src_coor_x (o_src_coor_x),
    .o_src_coor_y (o_src_coor_y),
    .o_dst_coor_x (o_dst_coor_x),
    .o_dst_coor_y (o_dst_coor_y),
    .o_last       (o_last),
    .o_frame_done (o_frame_done),
    .o_match_cnt  (o_match_cnt),
    .o_drop_cnt   (o_drop_cnt)
  );

  assign out_data = {o_src_coor_x, o_src_coor_y, o_dst_coor_x, o_dst_coor_y};

  typedef struct {
    logic [39:0] data;
    bit          chk_last;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cycles = 0;
  int          exp_match = 0;
  int          exp_drop = 0;
  logic [11:0] done_match = '0;
  logic [11:0] done_drop = '0;
  bit          stall_pend = 1'b0;
  logic [39:0] held = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  // Drive one pair for one cycle; room=0 marks a pair the FIFO cannot take.
  task automatic send(input int sx, input int sy, input int dx, input int dy,
                      input bit e, input bit room, input bit chk, input bit last);
    i_valid      = 1'b1;
    i_end        = e;
    i_src_coor_x = 10'(sx);
    i_src_coor_y = 10'(sy);
    i_dst_coor_x = 10'(dx);
    i_dst_coor_y = 10'(dy);
    if ((absdiff(dx, sx) + absdiff(dy, sy) <= MAX_D) && room) begin
      sb.push_back('{data: {10'(sx), 10'(sy), 10'(dx), 10'(dy)}, chk_last: chk, last: last});
      exp_match++;
    end else begin
      exp_drop++;
    end
    tick();
    i_valid = 1'b0;
    i_end   = 1'b0;
  endtask

  task automatic end_frame();
    i_end = 1'b1;
    tick();
    i_end = 1'b0;
  endtask

  task automatic frame_check(input string tag, input int lim, output int n);
    n = 0;
    while (done_cycles == 0 && n < lim) begin
      tick();
      n++;
    end
    check_val({tag, "_done_seen"}, 64'(done_cycles != 0), 64'd1);
    check_val({tag, "_match_cnt"}, 64'(done_match), 64'(exp_match));
    check_val({tag, "_drop_cnt"}, 64'(done_drop), 64'(exp_drop));
    tick();
    check_val({tag, "_done_1cyc"}, 64'(done_cycles), 64'd1);
    check_val({tag, "_cnt_clear"}, 64'({o_match_cnt, o_drop_cnt}), 64'd0);
    check_val({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    done_cycles = 0;
    exp_match   = 0;
    exp_drop    = 0;
  endtask

  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check_val("stall_valid", 64'(o_valid), 64'd1);
        check_val("stall_data", 64'(out_data), 64'(held));
      end
      stall_pend = o_valid && !i_ready;
      held       = out_data;
      if (o_valid && i_ready) begin
        check_val("out_sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("out_data", 64'(out_data), 64'(e.data));
          if (e.chk_last) check_val("out_last", 64'(o_last), 64'(e.last));
        end
      end
      if (o_frame_done) begin
        done_cycles++;
        done_match = o_match_cnt;
        done_drop  = o_drop_cnt;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int sx, sy, dx, dy, g;

    repeat (3) tick();
    check_val("rst_valid", 64'(o_valid), 64'd0);
    check_val("rst_last", 64'(o_last), 64'd0);
    check_val("rst_done", 64'(o_frame_done), 64'd0);
    check_val("rst_cnts", 64'({o_match_cnt, o_drop_cnt}), 64'd0);
    check_val("rst_data", 64'(out_data), 64'd0);
    i_rst = 1'b0;
    tick();

    // Frame 1: the middle pair exceeds the displacement limit.
    i_ready = 1'b1;
    send(0, 0, 5, 5, 1'b0, 1'b1, 1'b1, 1'b0);
    send(10, 10, 300, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    send(20, 20, 25, 22, 1'b0, 1'b1, 1'b1, 1'b1);
    end_frame();
    frame_check("f1", 50, n);

    // Frame 2: overfill while stalled, then drain.
    i_ready = 1'b0;
    for (int i = 0; i < 70; i++)
      send(i, 2 * i, i, 2 * i, 1'b0, (i < 64), 1'b1, (i == 63));
    end_frame();
    i_ready = 1'b1;
    frame_check("f2", 300, n);

    // Frame 3: empty frame.
    end_frame();
    frame_check("f3", 10, n);
    check_val("f3_done_latency_le2", 64'(n <= 2), 64'd1);

    // Frame 4: pair together with i_end.
    send(7, 8, 9, 10, 1'b1, 1'b1, 1'b1, 1'b1);
    frame_check("f4", 20, n);

    // Mid-frame reset discards buffered pairs.
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(100 + i, 50, 110 + i, 60, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("pre_rst_match", 64'(o_match_cnt), 64'd5);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_val("post_rst_valid", 64'(o_valid), 64'd0);
    check_val("post_rst_cnts", 64'({o_match_cnt, o_drop_cnt}), 64'd0);
    sb.delete();
    exp_match   = 0;
    exp_drop    = 0;
    done_cycles = 0;
    i_ready     = 1'b1;
    repeat (10) tick();
    check_val("post_rst_no_done", 64'(done_cycles), 64'd0);

    // Random frame: 200 pairs, random i_ready, bounded occupancy.
    for (int i = 0; i < 200; i++) begin
      g = 0;
      while (sb.size() >= 60 && g < 1000) begin
        i_ready = 1'($urandom_range(0, 1));
        tick();
        g++;
      end
      i_ready = 1'($urandom_range(0, 1));
      sx = int'($urandom_range(0, 1023));
      sy = int'($urandom_range(0, 1023));
      dx = clamp(sx + int'($urandom_range(0, 300)) - 150);
      dy = clamp(sy + int'($urandom_range(0, 300)) - 150);
      send(sx, sy, dx, dy, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    end_frame();
    // This pair arrives in DRAIN and must be dropped.
    i_valid      = 1'b1;
    i_src_coor_x = 10'd1;
    i_src_coor_y = 10'd1;
    i_dst_coor_x = 10'd1;
    i_dst_coor_y = 10'd1;
    exp_drop++;
    tick();
    i_valid = 1'b0;
    g = 0;
    while (done_cycles == 0 && g < 3000) begin
      i_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    i_ready = 1'b1;
    frame_check("rnd", 10, n);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
